// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shared front end for the 12-bit ALU datapath. Two requesters hand in
// operand/opcode transactions over valid/ready. One winner is accepted per
// transaction, its payload is captured, a single ALU evaluation is done from
// the captured registers, and the registered result plus flags are returned
// over a response handshake tagged with the requester ID.
//
// Ports:
//   clk                      rising-edge clock
//   rst                      synchronous, active-high reset
//   req0_valid / req1_valid  requester has a transaction pending
//   req0_ready / req1_ready  transaction accepted this cycle (IDLE only)
//   req0_a, req0_b, req0_op  requester 0 operands (12b) and opcode (3b)
//   req1_a, req1_b, req1_op  requester 1 operands (12b) and opcode (3b)
//   rsp_valid / rsp_ready    response handshake
//   rsp_id                   requester that issued the result
//   rsp_z                    12-bit result
//   rsp_carry/sign/ov        carry-or-borrow, sign, signed overflow
//   busy                     high whenever a transaction is in flight
//
// Configuration macro:
//   ALU_ARB_FIXED_PRIO_EN    defined: requester 0 always wins a tie and the
//                            last-grant pointer is removed.
//                            undefined (default): round-robin on ties.
// ---------------------------------------------------------------------------
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [11:0] req0_a,
    input  logic [11:0] req0_b,
    input  logic [2:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [11:0] req1_a,
    input  logic [11:0] req1_b,
    input  logic [2:0]  req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [11:0] rsp_z,
    output logic        rsp_carry,
    output logic        rsp_sign,
    output logic        rsp_ov,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic [11:0] a_q, b_q;
    logic [2:0]  op_q;
    logic        id_q;

    logic        grant_id;
    logic        accept;

    logic [11:0] alu_z;
    logic        alu_carry;
    logic        alu_ov;
    logic [12:0] sum;
    logic [12:0] diff;
    logic [11:0] neg_a;

    // Winner selection. On a tie the round-robin build favours whichever
    // requester was not granted last; a lone valid requester always wins.
`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_id = ~req0_valid;
    end
`else
    logic last_q;

    always_comb begin
        grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_q;
        end else begin
            grant_id = ~req0_valid;
        end
    end

    // The pointer only moves on an accepted request. It resets to 1 so that
    // requester 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant_id;
        end
    end
`endif

    assign accept     = (state_q == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant_id;
    assign req1_ready = accept && grant_id;

    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one cycle to accept, one to evaluate, then hold the
    // response until the consumer takes it. No accept happens in RESP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:                   state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // Payload is sampled only in the accept cycle, from the winner.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            id_q <= 1'b0;
        end else if (accept) begin
            a_q  <= grant_id ? req1_a  : req0_a;
            b_q  <= grant_id ? req1_b  : req0_b;
            op_q <= grant_id ? req1_op : req0_op;
            id_q <= grant_id;
        end
    end

    // The 13th bit of the subtraction is the borrow, set exactly when A < B
    // as unsigned numbers.
    assign sum   = {1'b0, a_q} + {1'b0, b_q};
    assign diff  = {1'b0, a_q} - {1'b0, b_q};
    assign neg_a = ~a_q + 12'd1;

    // ALU evaluated only from the captured registers; every flag is derived
    // fresh for each operation.
    always_comb begin
        alu_z     = '0;
        alu_carry = 1'b0;
        alu_ov    = 1'b0;
        case (op_q)
            3'd0: begin
                // Negating 0x800 wraps back to 0x800, which is the overflow case.
                alu_z  = a_q[11] ? neg_a : a_q;
                alu_ov = (a_q == 12'h800);
            end
            3'd1: alu_z = {b_q[10:0], 1'b0};
            3'd2: alu_z = a_q & b_q;
            3'd3: alu_z = a_q | b_q;
            3'd4: alu_z = a_q ^ b_q;
            3'd5: alu_z = ~a_q;
            3'd6: begin
                alu_z     = sum[11:0];
                alu_carry = sum[12];
                alu_ov    = (a_q[11] == b_q[11]) && (sum[11] != a_q[11]);
            end
            3'd7: begin
                alu_z     = diff[11:0];
                alu_carry = diff[12];
                alu_ov    = (a_q[11] != b_q[11]) && (diff[11] != a_q[11]);
            end
            default: ;
        endcase
    end

    // Response registers load at the end of EXEC and then stay put through
    // RESP, so the consumer sees stable values however long it stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id    <= 1'b0;
            rsp_z     <= '0;
            rsp_carry <= 1'b0;
            rsp_sign  <= 1'b0;
            rsp_ov    <= 1'b0;
        end else if (state_q == EXEC) begin
            rsp_id    <= id_q;
            rsp_z     <= alu_z;
            rsp_carry <= alu_carry;
            rsp_sign  <= alu_z[11];
            rsp_ov    <= alu_ov;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Self-checking bench for alu_arbiter. A transaction-level model (arbitration
// rule, in-flight transaction, integer-arithmetic ALU) is compared against the
// DUT on every falling edge, and directed vectors carry hand-computed result
// literals. Honours ALU_ARB_FIXED_PRIO_EN for the tie-breaking expectations.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [11:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [11:0] rsp_z;
    logic        rsp_carry, rsp_sign, rsp_ov;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_z      (rsp_z),
        .rsp_carry  (rsp_carry),
        .rsp_sign   (rsp_sign),
        .rsp_ov     (rsp_ov),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: every check funnels through here.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // ALU reference computed with plain signed/unsigned integer arithmetic.
    function automatic void aluModel(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b,
                                     output logic [11:0] z, output logic c, output logic v);
        int ua, ub, sa, sb, r, s;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 2048) ? ua - 4096 : ua;
        sb = (ub >= 2048) ? ub - 4096 : ub;
        z = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'd0: begin
                r = (sa < 0) ? -sa : sa;
                v = (r > 2047);
                z = r[11:0];
            end
            3'd1: begin
                r = ub * 2;
                z = r[11:0];
            end
            3'd2: z = a & b;
            3'd3: z = a | b;
            3'd4: z = a ^ b;
            3'd5: z = ~a;
            3'd6: begin
                r = ua + ub;
                c = (r > 4095);
                z = r[11:0];
                s = sa + sb;
                v = (s > 2047) || (s < -2048);
            end
            default: begin
                r = ua - ub;
                c = (ua < ub);
                z = r[11:0];
                s = sa - sb;
                v = (s > 2047) || (s < -2048);
            end
        endcase
    endfunction

    // ---------------- requester driver ----------------
    logic [26:0] q0[$];
    logic [26:0] q1[$];
    logic        acc0 = 1'b0, acc1 = 1'b0;

    always @(negedge clk) begin
        acc0 = req0_ready && !rst;
        acc1 = req1_ready && !rst;
    end

    task automatic applyStimulus(input logic id, input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        if (id) q1.push_back({op, a, b});
        else    q0.push_back({op, a, b});
    endtask

    // Each requester keeps valid and payload steady until it was accepted,
    // then presents its next queued transaction straight away.
    initial begin
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        forever begin
            @(posedge clk);
            #1;
            if (req0_valid && acc0) begin
                void'(q0.pop_front());
                req0_valid = 1'b0;
            end
            if (!req0_valid && q0.size() > 0) begin
                {req0_op, req0_a, req0_b} = q0[0];
                req0_valid = 1'b1;
            end
            if (req1_valid && acc1) begin
                void'(q1.pop_front());
                req1_valid = 1'b0;
            end
            if (!req1_valid && q1.size() > 0) begin
                {req1_op, req1_a, req1_b} = q1[0];
                req1_valid = 1'b1;
            end
        end
    end

    // ---------------- transaction-level model + compare ----------------
    logic        rstSeen = 1'b1;
    always @(posedge clk) rstSeen <= rst;

    int          cycle    = 0;
    logic        mPending = 1'b0;
    int          mAcc     = 0;
    logic        mLast    = 1'b1;
    logic        tId;
    logic [2:0]  tOp;
    logic [11:0] tA, tB;
    logic        hId = 1'b0;
    logic [11:0] hZ  = '0;
    logic        hC  = 1'b0, hV = 1'b0;
    int          grantLog[$];

    always @(negedge clk) begin
        logic expR0, expR1, expValid, win;
        if (rstSeen) begin
            mPending = 1'b0;
            mLast    = 1'b1;
            hId = 1'b0; hZ = '0; hC = 1'b0; hV = 1'b0;
        end
        cycle++;
        expR0 = 1'b0;
        expR1 = 1'b0;
        win   = 1'b0;
        if (!mPending && (req0_valid || req1_valid)) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
                win = 1'b0;
`else
                win = (mLast == 1'b1) ? 1'b0 : 1'b1;
`endif
            end else begin
                win = req1_valid;
            end
            expR0 = !win;
            expR1 = win;
        end
        if (mPending && cycle == mAcc + 2) begin
            hId = tId;
            aluModel(tOp, tA, tB, hZ, hC, hV);
        end
        expValid = mPending && (cycle >= mAcc + 2);

        checkOutput("req0_ready", req0_ready, expR0);
        checkOutput("req1_ready", req1_ready, expR1);
        checkOutput("rsp_valid", rsp_valid, expValid);
        checkOutput("busy", busy, mPending);
        checkOutput("rsp_id", rsp_id, hId);
        checkOutput("rsp_z", rsp_z, hZ);
        checkOutput("rsp_carry", rsp_carry, hC);
        checkOutput("rsp_sign", rsp_sign, hZ[11]);
        checkOutput("rsp_ov", rsp_ov, hV);

        if (expValid && rsp_ready) begin
            mPending = 1'b0;
        end else if (!mPending && !rst && (expR0 || expR1)) begin
            mPending = 1'b1;
            mAcc     = cycle;
            tId      = win;
            tOp      = win ? req1_op : req0_op;
            tA       = win ? req1_a  : req0_a;
            tB       = win ? req1_b  : req0_b;
            mLast    = win;
            grantLog.push_back(int'(win));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic waitRsp(output int latency);
        int n = 0;
        latency = -1;
        while (!(req0_ready || req1_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!(req0_ready || req1_ready)) begin
            checkOutput("acceptTimeout", 32'd0, 32'd1);
            return;
        end
        latency = 0;
        while (!rsp_valid && latency < 50) begin
            @(negedge clk);
            latency++;
        end
        if (!rsp_valid) checkOutput("rspTimeout", 32'd0, 32'd1);
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((busy || req0_valid || req1_valid || q0.size() > 0 || q1.size() > 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (busy || req0_valid || req1_valid) checkOutput("idleTimeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic checkRsp(input string name, input logic id, input logic [11:0] z,
                            input logic c, input logic s, input logic v);
        checkOutput({name, ".id"}, rsp_id, id);
        checkOutput({name, ".z"}, rsp_z, z);
        checkOutput({name, ".carry"}, rsp_carry, c);
        checkOutput({name, ".sign"}, rsp_sign, s);
        checkOutput({name, ".ov"}, rsp_ov, v);
    endtask

    typedef struct packed {
        logic        id;
        logic [2:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] z;
        logic        c;
        logic        s;
        logic        v;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int lat;
        int base;
        int n;
        int expOrder[8];

        vecs[0]  = '{1'b0, 3'd6, 12'h7FF, 12'h001, 12'h800, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, 3'd7, 12'h003, 12'h005, 12'hFFE, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 12'h800, 12'h000, 12'h800, 1'b0, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 3'd0, 12'hFFB, 12'h000, 12'h005, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 3'd1, 12'h000, 12'hC01, 12'h802, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 3'd2, 12'hF0F, 12'h0FF, 12'h00F, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 3'd3, 12'hF00, 12'h00F, 12'hF0F, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 3'd4, 12'hFF0, 12'h0FF, 12'hF0F, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 3'd5, 12'h0F0, 12'h000, 12'hF0F, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 3'd6, 12'hFFF, 12'h001, 12'h000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 3'd7, 12'h800, 12'h001, 12'h7FF, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 3'd6, 12'h400, 12'h400, 12'h800, 1'b0, 1'b1, 1'b1};

        rst       = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        $display("[TB] reset values");
        checkOutput("reset.req0_ready", req0_ready, 1'b0);
        checkOutput("reset.req1_ready", req1_ready, 1'b0);
        checkOutput("reset.busy", busy, 1'b0);
        checkOutput("reset.rsp_valid", rsp_valid, 1'b0);
        checkRsp("reset", 1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

        $display("[TB] directed ALU vectors");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b);
            waitRsp(lat);
            checkOutput($sformatf("vec%0d.latency", i), lat, 32'd2);
            checkRsp($sformatf("vec%0d", i), vecs[i].id, vecs[i].z, vecs[i].c, vecs[i].s, vecs[i].v);
        end
        waitIdle();

        $display("[TB] grant order with both requesters valid");
        doReset();
        base = grantLog.size();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 3'd6, 12'(i), 12'h010);
            applyStimulus(1'b1, 3'd7, 12'(i), 12'h001);
        end
`ifdef ALU_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        expOrder = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        n = 0;
        while (grantLog.size() < base + 8 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (grantLog.size() < base + 8) begin
            checkOutput("grantTimeout", 32'd0, 32'd1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                checkOutput($sformatf("grant%0d", i), grantLog[base + i], expOrder[i]);
            end
        end
        waitIdle();

        $display("[TB] response back-pressure");
        rsp_ready = 1'b0;
        applyStimulus(1'b1, 3'd2, 12'hF0F, 12'h0FF);
        waitRsp(lat);
        applyStimulus(1'b0, 3'd3, 12'h001, 12'h002);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput($sformatf("hold%0d.rsp_valid", i), rsp_valid, 1'b1);
            checkOutput($sformatf("hold%0d.busy", i), busy, 1'b1);
            checkOutput($sformatf("hold%0d.req0_ready", i), req0_ready, 1'b0);
            checkOutput($sformatf("hold%0d.req1_ready", i), req1_ready, 1'b0);
            checkRsp($sformatf("hold%0d", i), 1'b1, 12'h00F, 1'b0, 1'b0, 1'b0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("release.req0_ready", req0_ready, 1'b0);
        @(negedge clk);
        checkOutput("afterRelease.req0_ready", req0_ready, 1'b1);
        waitRsp(lat);
        checkRsp("afterRelease", 1'b0, 12'h003, 1'b0, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] reset during EXEC");
        applyStimulus(1'b0, 3'd4, 12'h0AA, 12'h055);
        n = 0;
        while (!req0_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort.accept", req0_ready, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.rsp_valid", rsp_valid, 1'b0);
        checkOutput("abort.rsp_z", rsp_z, 12'h000);
        applyStimulus(1'b0, 3'd3, 12'h100, 12'h001);
        applyStimulus(1'b1, 3'd3, 12'h200, 12'h002);
        n = 0;
        while (!(req0_ready || req1_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort.tieWinner0", req0_ready, 1'b1);
        checkOutput("abort.tieLoser1", req1_ready, 1'b0);
        waitIdle();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
